// File: rtl/sha256_msg_sched.sv
// sha256_msg_sched: SHA-256 message-schedule sequencer.
// The sequencer loads one 512-bit block as 16 big-endian words W[0..15].
// It then streams W[0..NUM_ROUNDS-1], one word per handshake, from a
// 16-word sliding window.
// Optional macro MSG_SCHED_PIPE_EN: when defined, the expansion sum is
// registered before it enters the window. This cuts the rotate/adder path,
// and the block then emits one word every two cycles.
module sha256_msg_sched #(
    parameter int NUM_ROUNDS = 64
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        in_valid,
    output logic        in_ready,
    input  logic [31:0] in_word,
    output logic        out_valid,
    input  logic        out_ready,
    output logic [31:0] out_word,
    output logic [5:0]  out_idx,
    output logic        out_last,
    output logic        busy,
    output logic        done
);

    localparam int DATA_W = 32;

    typedef enum logic [2:0] {
        S_IDLE,
        S_LOAD,
        S_RUN,
        S_RFSH,
        S_DONE
    } state_t;

    state_t              state;
    state_t              state_nxt;
    logic [DATA_W-1:0]   win [16];
    logic [4:0]          cnt;
    logic [5:0]          t;
    logic [DATA_W-1:0]   next_p0;
    logic                is_last;
    logic                load_shift;
    logic                xfer;
    logic                run_shift;

    // small sigma functions of the message schedule
    function automatic logic [DATA_W-1:0] sig0(input logic [DATA_W-1:0] x);
        return {x[6:0], x[31:7]} ^ {x[17:0], x[31:18]} ^ (x >> 3);
    endfunction

    function automatic logic [DATA_W-1:0] sig1(input logic [DATA_W-1:0] x);
        return {x[16:0], x[31:17]} ^ {x[18:0], x[31:19]} ^ (x >> 10);
    endfunction

    assign next_p0    = sig1(win[14]) + win[9] + sig0(win[1]) + win[0];
    assign is_last    = (t == 6'(NUM_ROUNDS - 1));
    assign load_shift = ((state == S_IDLE) || (state == S_LOAD)) && in_valid;
    assign xfer       = (state == S_RUN) && out_ready;
    assign run_shift  = xfer && !is_last;

    // state register
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state <= S_IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    // next-state logic
    always_comb begin
        state_nxt = state;
        case (state)
            S_IDLE: if (in_valid) state_nxt = S_LOAD;
            S_LOAD: if (in_valid && (cnt == 5'd15)) state_nxt = S_RUN;
            S_RUN: begin
                if (xfer) begin
                    if (is_last) begin
                        state_nxt = S_DONE;
                    end else begin
`ifdef MSG_SCHED_PIPE_EN
                        state_nxt = S_RFSH;
`else
                        state_nxt = S_RUN;
`endif
                    end
                end
            end
            S_RFSH: state_nxt = S_RUN;
            S_DONE: state_nxt = S_IDLE;
            default: state_nxt = S_IDLE;
        endcase
    end

    // output decode
    always_comb begin
        in_ready  = (state == S_IDLE) || (state == S_LOAD);
        out_valid = (state == S_RUN);
        out_word  = (state == S_RUN) ? win[0] : '0;
        out_idx   = t;
        out_last  = (state == S_RUN) && is_last;
        busy      = (state != S_IDLE);
        done      = (state == S_DONE);
    end

    // load counter and schedule index; both clear when the block finishes
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            cnt <= '0;
            t   <= '0;
        end else begin
            case (state)
                S_IDLE: if (in_valid) cnt <= 5'd1;
                S_LOAD: if (in_valid) cnt <= cnt + 5'd1;
                S_RUN:  if (run_shift) t <= t + 6'd1;
                S_DONE: begin
                    cnt <= '0;
                    t   <= '0;
                end
                default: ;
            endcase
        end
    end

`ifdef MSG_SCHED_PIPE_EN
    logic [DATA_W-1:0] nxt_p1;

    // pipeline register holding the expansion sum of the pre-shift window
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            nxt_p1 <= '0;
        end else if (run_shift) begin
            nxt_p1 <= next_p0;
        end
    end

    // sliding window: load shifts in input words; run shifts and refills win[15] a cycle later
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int k = 0; k < 16; k++) win[k] <= '0;
        end else if (load_shift) begin
            for (int k = 0; k < 15; k++) win[k] <= win[k+1];
            win[15] <= in_word;
        end else if (run_shift) begin
            for (int k = 0; k < 15; k++) win[k] <= win[k+1];
        end else if (state == S_RFSH) begin
            win[15] <= nxt_p1;
        end
    end
`else
    // sliding window: load shifts in input words; run shifts in the expansion sum
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int k = 0; k < 16; k++) win[k] <= '0;
        end else if (load_shift) begin
            for (int k = 0; k < 15; k++) win[k] <= win[k+1];
            win[15] <= in_word;
        end else if (run_shift) begin
            for (int k = 0; k < 15; k++) win[k] <= win[k+1];
            win[15] <= next_p0;
        end
    end
`endif

endmodule

// File: tb/tb_sha256_msg_sched.sv
// Scoreboard bench for sha256_msg_sched: a software schedule model fills a
// queue at load time, and a negedge monitor pops it on every transfer.
module tb_sha256_msg_sched;

    localparam int NR = 64;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        in_valid = 1'b0;
    logic        in_ready;
    logic [31:0] in_word = '0;
    logic        out_valid;
    logic        out_ready = 1'b1;
    logic [31:0] out_word;
    logic [5:0]  out_idx;
    logic        out_last;
    logic        busy;
    logic        done;

    sha256_msg_sched #(.NUM_ROUNDS(NR)) dut (
        .clk(clk), .rst(rst),
        .in_valid(in_valid), .in_ready(in_ready), .in_word(in_word),
        .out_valid(out_valid), .out_ready(out_ready), .out_word(out_word),
        .out_idx(out_idx), .out_last(out_last), .busy(busy), .done(done)
    );

    always #5 clk = ~clk;

    typedef struct packed {
        logic [31:0] w;
        logic [5:0]  idx;
        logic        last;
    } exp_t;

    exp_t        q[$];
    int          n_chk = 0;
    int          n_err = 0;
    int          done_cnt = 0;
    int          n_blocks = 0;
    bit          exp_done = 1'b0;
    bit          rdy_rand = 1'b0;
    bit          prev_stall = 1'b0;
    logic [31:0] prev_w;
    logic [5:0]  prev_idx;
    logic [31:0] got_w [64];
    exp_t        e;

    task automatic chk(input string name, input logic [31:0] got, input logic [31:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got 0x%08h required 0x%08h (t=%0t)", name, got, exp, $time);
        end
    endtask

    function automatic logic [31:0] rr(input logic [31:0] x, input int n);
        return (x >> n) | (x << (32 - n));
    endfunction

    function automatic logic [31:0] ms0(input logic [31:0] x);
        return rr(x, 7) ^ rr(x, 18) ^ (x >> 3);
    endfunction

    function automatic logic [31:0] ms1(input logic [31:0] x);
        return rr(x, 17) ^ rr(x, 19) ^ (x >> 10);
    endfunction

    // reference: textbook SHA-256 schedule expansion, all words pushed as expectations
    task automatic push_block(input logic [31:0] m[16]);
        logic [31:0] w [64];
        exp_t x;
        for (int i = 0; i < 16; i++) w[i] = m[i];
        for (int i = 16; i < 64; i++) w[i] = ms1(w[i-2]) + w[i-7] + ms0(w[i-15]) + w[i-16];
        for (int i = 0; i < NR; i++) begin
            x.w = w[i];
            x.idx = 6'(i);
            x.last = (i == NR - 1);
            q.push_back(x);
        end
    endtask

    task automatic load_block(input logic [31:0] m[16], input int gap, input bit hold);
        push_block(m);
        for (int i = 0; i < 16; i++) begin
            for (int k = 0; k < gap; k++) begin
                in_valid = 1'b0;
                chk("in_ready_gap", 32'(in_ready), 32'd1);
                @(posedge clk); #1;
            end
            in_valid = 1'b1;
            in_word  = m[i];
            chk("in_ready_load", 32'(in_ready), 32'd1);
            @(posedge clk); #1;
        end
        if (hold) begin
            in_valid = 1'b1;
            in_word  = 32'hDEADBEEF;
        end else begin
            in_valid = 1'b0;
        end
    endtask

    task automatic run_block(input logic [31:0] m[16], input int gap, input bit hold, output int cyc);
        bit got;
        load_block(m, gap, hold);
        cyc = 0;
        got = 1'b0;
        while (!got && cyc < 3000) begin
            if (hold) chk("in_ready_run", 32'(in_ready), 32'd0);
            @(posedge clk); #1;
            cyc++;
            if (done) got = 1'b1;
        end
        in_valid = 1'b0;
        if (!got) begin
            n_chk++;
            n_err++;
            $display("FAIL done_timeout: got no done within %0d cycles", cyc);
        end
        n_blocks++;
        @(posedge clk); #1;
        chk("done_one_cycle", 32'(done), 32'd0);
        chk("idle_after_done", 32'(busy), 32'd0);
    endtask

    // monitor: scoreboard pops, stall stability and done pulse checks
    always @(negedge clk) begin
        if (rst) begin
            prev_stall = 1'b0;
        end else begin
            if (exp_done) begin
                chk("done_pulse", 32'(done), 32'd1);
                exp_done = 1'b0;
            end else if (done) begin
                n_err++;
                $display("FAIL done_unexpected: got 1 required 0 (t=%0t)", $time);
            end
            if (done) done_cnt++;
            if (prev_stall) begin
                chk("stall_valid", 32'(out_valid), 32'd1);
                chk("stall_word", out_word, prev_w);
                chk("stall_idx", 32'(out_idx), 32'(prev_idx));
            end
            if (out_valid && out_ready) begin
                if (q.size() == 0) begin
                    n_chk++;
                    n_err++;
                    $display("FAIL extra_word: got idx %0d word 0x%08h required none", out_idx, out_word);
                end else begin
                    e = q.pop_front();
                    chk("word", out_word, e.w);
                    chk("idx", 32'(out_idx), 32'(e.idx));
                    chk("last", 32'(out_last), 32'(e.last));
                end
                got_w[out_idx] = out_word;
                if (out_last) exp_done = 1'b1;
            end
            prev_stall = out_valid && !out_ready;
            prev_w     = out_word;
            prev_idx   = out_idx;
        end
    end

    // consumer readiness: constant high or pseudo-random
    initial begin
        forever begin
            @(posedge clk); #1;
            out_ready = rdy_rand ? 1'($urandom_range(0, 1)) : 1'b1;
        end
    end

    task automatic chk_reset_outputs(input string tag);
        chk({tag, "_in_ready"}, 32'(in_ready), 32'd1);
        chk({tag, "_out_valid"}, 32'(out_valid), 32'd0);
        chk({tag, "_out_word"}, out_word, 32'd0);
        chk({tag, "_out_idx"}, 32'(out_idx), 32'd0);
        chk({tag, "_out_last"}, 32'(out_last), 32'd0);
        chk({tag, "_busy"}, 32'(busy), 32'd0);
        chk({tag, "_done"}, 32'(done), 32'd0);
    endtask

    initial begin
        logic [31:0] abc [16];
        logic [31:0] rb [16];
        int cyc;
        int k;
        for (int i = 0; i < 16; i++) abc[i] = '0;
        abc[0]  = 32'h61626380;
        abc[15] = 32'h00000018;

        #1;
        chk_reset_outputs("reset");
        @(posedge clk); @(posedge clk); #1;
        rst = 1'b0;

        // "abc" block, consumer always ready
        run_block(abc, 0, 1'b0, cyc);
`ifdef MSG_SCHED_PIPE_EN
        chk("cycles_to_done", 32'(cyc), 32'(2 * NR - 1));
`else
        chk("cycles_to_done", 32'(cyc), 32'(NR));
`endif
        chk("abc_w0", got_w[0], 32'h61626380);
        chk("abc_w15", got_w[15], 32'h00000018);
        chk("abc_w16", got_w[16], 32'h61626380);
        chk("abc_w17", got_w[17], 32'h000F0000);

        // same block with random consumer stalls
        rdy_rand = 1'b1;
        run_block(abc, 0, 1'b0, cyc);
        rdy_rand = 1'b0;

        // input gaps of 3 cycles between words
        run_block(abc, 3, 1'b0, cyc);

        // random block, in_valid held high with junk during RUN
        for (int i = 0; i < 16; i++) rb[i] = $urandom;
        run_block(rb, 0, 1'b1, cyc);

        // reset in the middle of RUN, then a fresh block
        load_block(abc, 0, 1'b0);
        k = 0;
        while (!(out_valid && out_idx == 6'd30) && k < 500) begin
            @(posedge clk); #1;
            k++;
        end
        if (k >= 500) begin
            n_chk++;
            n_err++;
            $display("FAIL reach_t30: got idx %0d required 30", out_idx);
        end
        #2;
        rst = 1'b1;
        q.delete();
        exp_done = 1'b0;
        #1;
        chk_reset_outputs("midrun_reset");
        @(posedge clk); @(posedge clk); #1;
        rst = 1'b0;
        run_block(abc, 0, 1'b0, cyc);

        // random blocks, random gaps and stalls
        for (int b = 0; b < 4; b++) begin
            for (int i = 0; i < 16; i++) rb[i] = $urandom;
            rdy_rand = 1'b1;
            run_block(rb, int'($urandom_range(0, 2)), 1'b0, cyc);
        end
        rdy_rand = 1'b0;

        repeat (3) @(posedge clk);
        #1;
        chk("queue_empty", 32'(q.size()), 32'd0);
        chk("done_count", 32'(done_cnt), 32'(n_blocks));
        chk("final_busy", 32'(busy), 32'd0);

        $display("Simulation finished: %0d checks, %0d errors", n_chk, n_err);
        $finish;
    end

endmodule
